mem_req_responder: RTL

Responder side of the 16-bit Rd/Wr/Done/Stall/CacheHit memory request protocol. It is a direct-mapped, write-back, write-allocate cache of 8 lines × 4 words × 16 bits, sitting between a requester (CPU or random bench) and a word-wide backing memory with a req/ack handshake. It accepts one request at a time and holds Stall while busy. Each request gets a single-cycle Done pulse, with CacheHit indicating whether the access hit.

---
 rtl/mem_req_responder_if.sv | 34 +++
 rtl/mem_req_responder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_req_responder_if.sv
// Requester-side and backing-memory-side signals of the cache responder.
// The slave modport is the responder's view. The master modport is the view
// of whoever drives the requests and models the backing memory.
interface mem_req_responder_if;
  // Requester side
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        Err;
  // Backing-memory side
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_ack, mem_rdata,
    output DataOut, Done, Stall, CacheHit, Err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_ack, mem_rdata,
    input  DataOut, Done, Stall, CacheHit, Err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_responder.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines x 4 words x 16 bits.
// Serves one Rd/Wr request at a time and refills and evicts lines through a
// word-wide req/ack backing memory.
module mem_req_responder (
  input  logic                 clk,
  input  logic                 rst,
  mem_req_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COMPARE, WB, FILL} state_e;

  state_e      state_q, state_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [1:0]  beat_q, beat_d;
  logic        mem_req_q, mem_req_d;
  logic        miss_q, miss_d;
  logic [7:0]  valid_q, valid_d;
  logic [7:0]  dirty_q, dirty_d;
  logic [9:0]  tag_q [8];
  logic [15:0] data_q [8][4];

  // Single write port into the data array, shared by fill beats and write hits
  logic        data_we;
  logic [1:0]  data_woff;
  logic [15:0] data_wdata;
  logic        tag_we;

  logic [2:0]  req_idx;
  logic [1:0]  req_off;
  logic [9:0]  req_tag;
  logic        hit;
  logic        reject;

  assign req_idx = req_addr_q[5:3];
  assign req_off = req_addr_q[2:1];
  assign req_tag = req_addr_q[15:6];
  assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign reject  = req_addr_q[0] || (bus.Rd && bus.Wr);

  // Next-state, beat handshake and array write-enable decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d    = state_q;
    req_addr_d = req_addr_q;
    beat_d     = beat_q;
    mem_req_d  = mem_req_q;
    miss_d     = miss_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    data_we    = 1'b0;
    data_woff  = req_off;
    data_wdata = bus.DataIn;
    tag_we     = 1'b0;

    case (state_q)
      IDLE: begin
        miss_d    = 1'b0;
        beat_d    = 2'd0;
        mem_req_d = 1'b0;
        if (bus.Rd || bus.Wr) begin
          req_addr_d = bus.Addr;
          state_d    = COMPARE;
        end
      end

      COMPARE: begin
        if (reject) begin
          miss_d  = 1'b0;
          state_d = IDLE;
        end else if (hit) begin
          if (bus.Wr) begin
            data_we          = 1'b1;
            dirty_d[req_idx] = 1'b1;
          end
          miss_d  = 1'b0;
          state_d = IDLE;
        end else begin
          miss_d  = 1'b1;
          beat_d  = 2'd0;
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WB : FILL;
        end
      end

      WB: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          beat_d    = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            dirty_d[req_idx] = 1'b0;
            state_d          = FILL;
          end
        end
      end

      FILL: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (bus.mem_ack) begin
          mem_req_d  = 1'b0;
          beat_d     = beat_q + 2'd1;
          data_we    = 1'b1;
          data_woff  = beat_q;
          data_wdata = bus.mem_rdata;
          if (beat_q == 2'd3) begin
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
            dirty_d[req_idx] = bus.Wr;
            state_d          = COMPARE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      beat_q     <= '0;
      mem_req_q  <= 1'b0;
      miss_q     <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      beat_q     <= beat_d;
      mem_req_q  <= mem_req_d;
      miss_q     <= miss_d;
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    // NOTE: tag and data arrays are not reset; valid bits guard them, and a reset-free array maps onto plain RAM.
    if (data_we) data_q[req_idx][data_woff] <= data_wdata;
    if (tag_we)  tag_q[req_idx]             <= req_tag;
  end

  // Requester response (COMPARE only) and beat outputs (zero between beats)
  always_comb begin
    bus.Stall     = (state_q != IDLE);
    bus.Done      = 1'b0;
    bus.Err       = 1'b0;
    bus.CacheHit  = 1'b0;
    bus.DataOut   = '0;
    bus.mem_req   = mem_req_q;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    if (state_q == COMPARE) begin
      if (reject) begin
        bus.Done = 1'b1;
        bus.Err  = 1'b1;
      end else if (hit) begin
        bus.Done     = 1'b1;
        // A hit that follows a refill of this same request still reports a miss
        bus.CacheHit = !miss_q;
        if (bus.Rd) bus.DataOut = data_q[req_idx][req_off];
      end
    end

    if (mem_req_q && (state_q == WB)) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = {tag_q[req_idx], req_idx, beat_q, 1'b0};
      bus.mem_wdata = data_q[req_idx][beat_q];
    end else if (mem_req_q && (state_q == FILL)) begin
      bus.mem_addr  = {req_tag, req_idx, beat_q, 1'b0};
    end
  end

endmodule
